// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared encodings for the data memory unit: access sizes,
//                dump FSM states and the alignment-fault helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    // Access size encodings carried on size_i
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_RSVD = 2'b11;

    // Debug dump FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    // An access faults when its size does not fit its byte offset, or when the
    // reserved size code is used at all.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            c_SIZE_BYTE: bad = 1'b0;
            c_SIZE_HALF: bad = offset[0];
            c_SIZE_WORD: bad = (offset != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational load formatter. Picks the byte, half or word
//                at the given byte offset, right-aligns it and sign- or
//                zero-extends it to 32 bits.
//  Ports       : i_word     - full 32-bit memory word
//                i_offset   - byte offset within the word
//                i_size     - access size (byte/half/word)
//                i_unsigned - zero-extend instead of sign-extend
//                o_data     - formatted load result
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        // Little-endian: moving the addressed lane down to bit 0 makes the
        // byte and half cases a simple truncation.
        w_shifted = i_word >> {i_offset, 3'b000};
        case (i_size)
            c_SIZE_BYTE: o_data = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            c_SIZE_HALF: o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:     o_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_unit
//  Description : Byte-addressable data memory with a CPU load/store port and
//                a low-priority debug dump engine that streams every word out
//                over a valid/ready interface. All state updates on the
//                falling edge of clock_i.
//  Ports       : clock_i, reset_i          - clock, synchronous active-high reset
//                enable_mem_i, mem_read_i,
//                mem_write_i, size_i,
//                unsigned_i, addr_i,
//                data_write_i              - CPU request
//                data_o, misaligned_o      - load result, alignment fault
//                dump_start_i, dump_ready_i- dump trigger, sink ready
//                dump_valid_o, dump_data_o,
//                dump_addr_o, dump_done_o  - dump stream and completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit
    import mips_mem_pkg::*;
#(
    parameter int N_ELEMENTS = 128,
    parameter int NB_ADDR    = $clog2(N_ELEMENTS) + 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_mem_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    input  logic [NB_ADDR-1:0] addr_i,
    input  logic [31:0]        data_write_i,
    output logic [31:0]        data_o,
    output logic               misaligned_o,
    input  logic               dump_start_i,
    input  logic               dump_ready_i,
    output logic               dump_valid_o,
    output logic [31:0]        dump_data_o,
    output logic [NB_ADDR-3:0] dump_addr_o,
    output logic               dump_done_o
);

    localparam int NB_WIDX = $clog2(N_ELEMENTS);
    localparam logic [NB_WIDX-1:0] c_LAST_IDX = NB_WIDX'(N_ELEMENTS - 1);

    logic [31:0]        r_mem [N_ELEMENTS];

    logic [31:0]        r_data;
    logic               r_misaligned;
    dump_state_t        r_state;
    logic [NB_WIDX-1:0] r_idx;
    logic               r_dump_valid;
    logic [31:0]        r_dump_data;
    logic [NB_ADDR-3:0] r_dump_addr;
    logic               r_dump_done;

    logic               w_cpu_active;
    logic               w_misaligned;
    logic               w_store;
    logic               w_load;
    logic [NB_WIDX-1:0] w_cpu_idx;
    logic [3:0]         w_lane_en;
    logic [31:0]        w_store_data;
    logic [31:0]        w_load_data;

    // Word index wraps on the memory depth; there is no out-of-range fault.
    assign w_cpu_idx    = addr_i[2 +: NB_WIDX];
    assign w_cpu_active = enable_mem_i & (mem_read_i | mem_write_i);
    assign w_misaligned = is_misaligned(size_i, addr_i[1:0]);
    assign w_store      = w_cpu_active & mem_write_i & ~w_misaligned;
    assign w_load       = w_cpu_active & mem_read_i  & ~w_misaligned;

    // Store lane enables; narrow store data is replicated so every lane
    // already carries the right byte and only the enables differ.
    always_comb begin
        w_lane_en    = 4'b0000;
        w_store_data = data_write_i;
        case (size_i)
            c_SIZE_BYTE: begin
                w_lane_en    = 4'b0001 << addr_i[1:0];
                w_store_data = {4{data_write_i[7:0]}};
            end
            c_SIZE_HALF: begin
                w_lane_en    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{data_write_i[15:0]}};
            end
            c_SIZE_WORD: w_lane_en = 4'b1111;
            default:     w_lane_en = 4'b0000;
        endcase
    end

    // Load path sees the word as it was before this edge's store, which gives
    // read-before-write on a combined access.
    dmem_lane_align u_load_align (
        .i_word     (r_mem[w_cpu_idx]),
        .i_offset   (addr_i[1:0]),
        .i_size     (size_i),
        .i_unsigned (unsigned_i),
        .o_data     (w_load_data)
    );

    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_ELEMENTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            for (int l = 0; l < 4; l++) begin
                if (w_lane_en[l]) begin
                    r_mem[w_cpu_idx][8*l +: 8] <= w_store_data[8*l +: 8];
                end
            end
        end
    end

    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            r_data       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_cpu_active & w_misaligned;
            if (w_load) begin
                r_data <= w_load_data;
            end
        end
    end

    // Dump engine. READ only samples memory on edges with no CPU access, so it
    // never races a store and words not yet sent reflect the newest writes.
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_addr  <= '0;
            r_dump_done  <= 1'b0;
        end else begin
            r_dump_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dump_start_i) begin
                        r_idx   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!w_cpu_active) begin
                        r_dump_data  <= r_mem[r_idx];
                        r_dump_addr  <= (NB_ADDR-2)'(r_idx);
                        r_dump_valid <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (dump_ready_i) begin
                        r_dump_valid <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_dump_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_o       = r_data;
    assign misaligned_o = r_misaligned;
    assign dump_valid_o = r_dump_valid;
    assign dump_data_o  = r_dump_data;
    assign dump_addr_o  = r_dump_addr;
    assign dump_done_o  = r_dump_done;

endmodule
`default_nettype wire
